// File: rtl/text_gfx_pipe.sv
`default_nettype none
// ============================================================================
// Module   : text_gfx_pipe
// Purpose  : Pipelined text-over-graphics pixel generator for the VGA path.
//            Converts raw timing counters into logical screen coordinates,
//            issues registered addresses to text/colour RAM, graphics RAM and
//            the charset ROM, and composes one COLOR_W pixel per clock with a
//            blinking block cursor. Sync is delayed to stay aligned with the
//            pixel. Total latency from inputs to pix_out_o is LAT = 6 edges.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1        pixel clock
//   rst_n          in   1        asynchronous active-low reset
//   pix_x_i        in   16       raw horizontal counter
//   pix_y_i        in   16       raw vertical counter
//   pix_active_i   in   1        visible-region flag from timing block
//   frame_start_i  in   1        one-cycle pulse at the start of each frame
//   sync_in_i      in   2        {vsync,hsync} from timing block
//   char_addr_o    out  CA_W     text/colour RAM address (registered)
//   gfx_addr_o     out  GA_W     graphics RAM address (registered)
//   char_code_i    in   8        text RAM data
//   fg_color_i     in   COLOR_W  colour RAM foreground
//   bg_color_i     in   COLOR_W  colour RAM background
//   bg_index_i     in   4        0 selects graphics as the background
//   gfx_in_i       in   COLOR_W  graphics RAM data
//   glyph_addr_o   out  8        charset ROM address (registered char code)
//   glyph_i        in   64       8x8 glyph, row-major, MSB = top-left
//   cursor_x_i     in   7        cursor column
//   cursor_y_i     in   5        cursor row
//   cursor_en_i    in   1        cursor enable
//   pix_out_o      out  COLOR_W  output pixel (registered)
//   sync_out_o     out  2        sync_in_i delayed LAT cycles
//   screen_en_o    out  1        output pixel lies inside the logical screen
// ============================================================================
module text_gfx_pipe #(
  parameter int TEXT_COLS    = 80,
  parameter int TEXT_ROWS    = 25,
  parameter int GFX_W        = 320,
  parameter int GFX_H        = 200,
  parameter int SCALE_LOG2   = 1,
  parameter int COLOR_W      = 8,
  parameter int BLINK_FRAMES = 30,
  localparam int CA_W        = $clog2(TEXT_COLS * TEXT_ROWS),
  localparam int GA_W        = $clog2(GFX_W * GFX_H),
  localparam int LAT         = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        pix_x_i,
  input  logic [15:0]        pix_y_i,
  input  logic               pix_active_i,
  input  logic               frame_start_i,
  input  logic [1:0]         sync_in_i,
  output logic [CA_W-1:0]    char_addr_o,
  output logic [GA_W-1:0]    gfx_addr_o,
  input  logic [7:0]         char_code_i,
  input  logic [COLOR_W-1:0] fg_color_i,
  input  logic [COLOR_W-1:0] bg_color_i,
  input  logic [3:0]         bg_index_i,
  input  logic [COLOR_W-1:0] gfx_in_i,
  output logic [7:0]         glyph_addr_o,
  input  logic [63:0]        glyph_i,
  input  logic [6:0]         cursor_x_i,
  input  logic [4:0]         cursor_y_i,
  input  logic               cursor_en_i,
  output logic [COLOR_W-1:0] pix_out_o,
  output logic [1:0]         sync_out_o,
  output logic               screen_en_o
);

  // Number of metadata stages between the input edge (E1) and the output
  // edge (E6): stages 1..5 hold the pixel after edges E1..E5.
  localparam int NSTG = LAT - 1;

  // Per-pixel metadata travelling alongside the memory accesses. The cursor
  // hit is resolved at E1 so that a pixel presented together with
  // frame_start still sees the cursor shadow and blink phase of the old frame.
  typedef struct packed {
    logic       in_scr;
    logic       hit;
    logic [1:0] sync;
    logic [2:0] fy;
    logic [2:0] fx;
  } meta_t;

  // Colour-RAM / graphics data captured at E3 and carried to the output.
  typedef struct packed {
    logic [COLOR_W-1:0] fg;
    logic [COLOR_W-1:0] bg;
    logic [COLOR_W-1:0] gfx;
    logic               bg_is_gfx;
  } cdat_t;

  localparam logic [15:0] GFX_W16 = 16'(GFX_W);
  localparam logic [15:0] GFX_H16 = 16'(GFX_H);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  meta_t              meta_q [1:NSTG];
  cdat_t              cdat_q [3:NSTG];
  logic [CA_W-1:0]    char_addr_q;
  logic [GA_W-1:0]    gfx_addr_q;
  logic [7:0]         glyph_addr_q;
  logic [63:0]        glyph_q;
  logic [COLOR_W-1:0] pix_out_q;
  logic [1:0]         sync_out_q;
  logic               screen_en_q;

  // Cursor shadow, loaded only on frame_start so a frame is never torn.
  logic [6:0]         cur_x_q;
  logic [4:0]         cur_y_q;
  logic               cur_en_q;

  logic               blink_phase;

  // --------------------------------------------------------------------------
  // E1 input stage: logical coordinates, screen test, address generation
  // --------------------------------------------------------------------------
  logic [15:0]        lx;
  logic [15:0]        ly;
  logic [15:0]        cell_x;
  logic [15:0]        cell_y;
  logic               in_scr;
  logic [CA_W-1:0]    char_addr_d;
  logic [GA_W-1:0]    gfx_addr_d;
  meta_t              meta_d;

  always_comb begin
    lx          = pix_x_i >> SCALE_LOG2;
    ly          = pix_y_i >> SCALE_LOG2;
    cell_x      = lx >> 3;
    cell_y      = ly >> 3;
    in_scr      = pix_active_i && (lx < GFX_W16) && (ly < GFX_H16);
    // Truncating arithmetic is safe: the result is only used when in_scr.
    char_addr_d = CA_W'(cell_y) * CA_W'(TEXT_COLS) + CA_W'(cell_x);
    gfx_addr_d  = GA_W'(ly) * GA_W'(GFX_W) + GA_W'(lx);

    meta_d        = '0;
    meta_d.in_scr = in_scr;
    meta_d.hit    = cur_en_q && !blink_phase &&
                    (cell_x == 16'(cur_x_q)) && (cell_y == 16'(cur_y_q));
    meta_d.sync   = sync_in_i;
    meta_d.fy     = ly[2:0];
    meta_d.fx     = lx[2:0];
  end

  // --------------------------------------------------------------------------
  // E6 output composition
  // --------------------------------------------------------------------------
  logic [5:0]         glyph_idx;
  logic               glyph_bit;
  logic [COLOR_W-1:0] pix_d;

  always_comb begin
    // Row-major glyph with the MSB at the top-left corner.
    glyph_idx = 6'd63 - {meta_q[NSTG].fy, meta_q[NSTG].fx};
    glyph_bit = glyph_q[glyph_idx] ^ meta_q[NSTG].hit;
    pix_d     = '0;
    if (meta_q[NSTG].in_scr) begin
      if (glyph_bit) begin
        pix_d = cdat_q[NSTG].fg;
      end else if (cdat_q[NSTG].bg_is_gfx) begin
        pix_d = cdat_q[NSTG].gfx;
      end else begin
        pix_d = cdat_q[NSTG].bg;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= NSTG; i++) begin
        meta_q[i] <= '0;
      end
      for (int i = 3; i <= NSTG; i++) begin
        cdat_q[i] <= '0;
      end
      char_addr_q  <= '0;
      gfx_addr_q   <= '0;
      glyph_addr_q <= '0;
      glyph_q      <= '0;
      pix_out_q    <= '0;
      sync_out_q   <= '0;
      screen_en_q  <= 1'b0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      cur_en_q     <= 1'b0;
    end else begin
      // E1
      meta_q[1] <= meta_d;
      if (in_scr) begin
        char_addr_q <= char_addr_d;
        gfx_addr_q  <= gfx_addr_d;
      end
      for (int i = 2; i <= NSTG; i++) begin
        meta_q[i] <= meta_q[i-1];
      end

      // E3: RAM data for the pixel addressed at E1 is valid now.
      cdat_q[3].fg        <= fg_color_i;
      cdat_q[3].bg        <= bg_color_i;
      cdat_q[3].gfx       <= gfx_in_i;
      cdat_q[3].bg_is_gfx <= (bg_index_i == 4'd0);
      glyph_addr_q        <= char_code_i;
      for (int i = 4; i <= NSTG; i++) begin
        cdat_q[i] <= cdat_q[i-1];
      end

      // E5: ROM data for the glyph address issued at E3.
      glyph_q <= glyph_i;

      // E6
      pix_out_q   <= pix_d;
      sync_out_q  <= meta_q[NSTG].sync;
      screen_en_q <= meta_q[NSTG].in_scr;

      if (frame_start_i) begin
        cur_x_q  <= cursor_x_i;
        cur_y_q  <= cursor_y_i;
        cur_en_q <= cursor_en_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Cursor blink: the phase toggles every BLINK_FRAMES frame_start pulses.
  // --------------------------------------------------------------------------
  generate
    if (BLINK_FRAMES == 0) begin : g_blink_off
      assign blink_phase = 1'b0;
    end else begin : g_blink_on
      localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

      logic [CNT_W-1:0] blink_cnt_q;
      logic             blink_phase_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= 1'b0;
        end else if (frame_start_i) begin
          if (blink_cnt_q == CNT_LAST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
          end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
          end
        end
      end

      assign blink_phase = blink_phase_q;
    end
  endgenerate

  assign char_addr_o  = char_addr_q;
  assign gfx_addr_o   = gfx_addr_q;
  assign glyph_addr_o = glyph_addr_q;
  assign pix_out_o    = pix_out_q;
  assign sync_out_o   = sync_out_q;
  assign screen_en_o  = screen_en_q;

endmodule
`default_nettype wire
